// File: rtl/bipolar_bundle_accumulator_f.sv
// bipolar_bundle_accumulator_f
// Streaming bundler: accumulates bipolar float elements (+1.0 / -1.0 / zero)
// into a signed integer sum and, at end of bundle, converts the sum back to
// float and presents it on a valid/ready output for the downstream cut stage.
//
// Optional feature macro: BUNDLE_SATURATE_EN
//   defined   - accumulator saturates symmetrically at +/-(2^(ACC_WIDTH-1)-1)
//               and a sticky overflow flag is reported with the result.
//   undefined - accumulator wraps in two's complement, overflow tied to 0.
module bipolar_bundle_accumulator_f #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int ACC_WIDTH      = 16
) (
    input  logic                                    clk,
    input  logic                                    reset_n,
    input  logic                                    in_valid,
    input  logic                                    in_last,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  elem_in,
    output logic                                    in_ready,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0]  elem_out,
    output logic                                    overflow
);

    localparam int W    = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    localparam int BIAS = (1 << (EXPONENT_WIDTH - 1)) - 1;
    localparam logic signed [ACC_WIDTH-1:0] ACC_ONE = {{(ACC_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        CONVERT = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t                         state_r;
    state_t                         state_s;
    logic signed [ACC_WIDTH-1:0]    acc_r;
    logic signed [ACC_WIDTH-1:0]    acc_next_s;
    logic signed [ACC_WIDTH-1:0]    contrib_s;
    logic [W-1:0]                   elem_out_r;

    logic                           sign_s;
    logic [ACC_WIDTH-1:0]           mag_s;
    int                             msb_s;
    logic [ACC_WIDTH-1:0]           norm_s;
    logic [ACC_WIDTH+MANTISSA_WIDTH-1:0] frac_wide_s;
    logic [MANTISSA_WIDTH-1:0]      mant_s;
    logic [EXPONENT_WIDTH-1:0]      exp_s;
    logic [W-1:0]                   result_s;
    logic                           unused_bits_s;

    // Element value: zero exponent means 0, otherwise +/-1 by sign bit.
    function automatic logic signed [ACC_WIDTH-1:0] decode_elem(
        input logic                      sgn,
        input logic [EXPONENT_WIDTH-1:0] expo
    );
        logic signed [ACC_WIDTH-1:0] c;
        if (expo == {EXPONENT_WIDTH{1'b0}}) begin
            c = '0;
        end else if (sgn) begin
            c = '1;
        end else begin
            c = ACC_ONE;
        end
        return c;
    endfunction

    // Index of the most significant set bit (0 when the value is zero).
    function automatic int msb_index(input logic [ACC_WIDTH-1:0] v);
        int idx;
        idx = 0;
        for (int i = 0; i < ACC_WIDTH; i++) begin
            if (v[i]) begin
                idx = i;
            end
        end
        return idx;
    endfunction

    assign contrib_s = decode_elem(elem_in[W-1], elem_in[W-2 -: EXPONENT_WIDTH]);

`ifdef BUNDLE_SATURATE_EN
    localparam logic signed [ACC_WIDTH:0] SAT_POS = (ACC_WIDTH+1)'((1 << (ACC_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_NEG = -SAT_POS;

    logic signed [ACC_WIDTH:0] sum_wide_s;
    logic                      sat_hit_s;
    logic                      sat_seen_r;
    logic                      overflow_r;

    // Add one guard bit, then clamp symmetrically and flag any clamped add.
    always_comb begin
        sum_wide_s = $signed({acc_r[ACC_WIDTH-1], acc_r}) + $signed({contrib_s[ACC_WIDTH-1], contrib_s});
        sat_hit_s  = 1'b0;
        acc_next_s = sum_wide_s[ACC_WIDTH-1:0];
        if (sum_wide_s > SAT_POS) begin
            acc_next_s = SAT_POS[ACC_WIDTH-1:0];
            sat_hit_s  = 1'b1;
        end else if (sum_wide_s < SAT_NEG) begin
            acc_next_s = SAT_NEG[ACC_WIDTH-1:0];
            sat_hit_s  = 1'b1;
        end else begin
            acc_next_s = sum_wide_s[ACC_WIDTH-1:0];
        end
    end

    // Sticky saturation flag per bundle, published with the result in CONVERT.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sat_seen_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (in_valid && sat_hit_s) begin
                        sat_seen_r <= 1'b1;
                    end
                end
                CONVERT: begin
                    overflow_r <= sat_seen_r;
                end
                HOLD: begin
                    if (out_ready) begin
                        sat_seen_r <= 1'b0;
                        overflow_r <= 1'b0;
                    end
                end
                default: begin
                    sat_seen_r <= 1'b0;
                    overflow_r <= 1'b0;
                end
            endcase
        end
    end

    assign overflow = overflow_r;
`else
    // Plain two's-complement accumulate; wraps silently.
    always_comb begin
        acc_next_s = acc_r + contrib_s;
    end

    assign overflow = 1'b0;
`endif

    // Integer-to-float conversion of the accumulator (truncating).
    always_comb begin
        sign_s = acc_r[ACC_WIDTH-1];
        if (sign_s) begin
            mag_s = $unsigned(~acc_r + ACC_ONE);
        end else begin
            mag_s = $unsigned(acc_r);
        end
        msb_s       = msb_index(mag_s);
        norm_s      = mag_s << (ACC_WIDTH - 1 - msb_s);
        frac_wide_s = {norm_s, {MANTISSA_WIDTH{1'b0}}};
        mant_s      = frac_wide_s[ACC_WIDTH+MANTISSA_WIDTH-2 -: MANTISSA_WIDTH];
        exp_s       = EXPONENT_WIDTH'(BIAS + msb_s);
        if (mag_s == {ACC_WIDTH{1'b0}}) begin
            result_s = '0;
        end else begin
            result_s = {sign_s, exp_s, mant_s};
        end
    end

    // Mantissa of the input and the leftover conversion bits carry no information.
    assign unused_bits_s = ^{elem_in[MANTISSA_WIDTH-1:0], frac_wide_s};

    // Next-state logic for the ACCUM -> CONVERT -> HOLD cycle.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ACCUM: begin
                if (in_valid && in_last) begin
                    state_s = CONVERT;
                end else begin
                    state_s = ACCUM;
                end
            end
            CONVERT: begin
                state_s = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    state_s = ACCUM;
                end else begin
                    state_s = HOLD;
                end
            end
            default: begin
                state_s = ACCUM;
            end
        endcase
    end

    // State, accumulator and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ACCUM;
            acc_r      <= '0;
            elem_out_r <= '0;
        end else begin
            state_r <= state_s;
            case (state_r)
                ACCUM: begin
                    if (in_valid) begin
                        acc_r <= acc_next_s;
                    end
                end
                CONVERT: begin
                    elem_out_r <= result_s;
                end
                HOLD: begin
                    if (out_ready) begin
                        acc_r <= '0;
                    end
                end
                default: begin
                    acc_r <= '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_r == ACCUM);
    assign out_valid = (state_r == HOLD);
    assign elem_out  = elem_out_r;

endmodule

// File: tb/tb_bipolar_bundle_accumulator_f.sv
// Directed, table-driven bench for bipolar_bundle_accumulator_f.
// Two instances share all inputs: the default build (ACC_WIDTH=16) and a
// narrow one (ACC_WIDTH=4) that exercises wrap/saturation.
module tb_bipolar_bundle_accumulator_f;

    localparam logic [31:0] P  = 32'h3F80_0000;
    localparam logic [31:0] N  = 32'hBF80_0000;
    localparam logic [31:0] Z  = 32'h0000_0000;
    localparam logic [31:0] NZ = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_last;
    logic [31:0] elem_in;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_overflow;
    logic [31:0] a_elem_out;
    logic        b_in_ready, b_out_valid, b_overflow;
    logic [31:0] b_elem_out;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int               n;
        logic [9:0][31:0] elems;
        logic [31:0]      exp_a;
        logic             ovf_a;
        logic [31:0]      exp_b;
        logic             ovf_b;
    } vec_t;

    vec_t vecs [8];

    bipolar_bundle_accumulator_f dut_a (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
        .elem_in(elem_in), .in_ready(a_in_ready), .out_valid(a_out_valid),
        .out_ready(out_ready), .elem_out(a_elem_out), .overflow(a_overflow)
    );

    bipolar_bundle_accumulator_f #(.ACC_WIDTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_last(in_last),
        .elem_in(elem_in), .in_ready(b_in_ready), .out_valid(b_out_valid),
        .out_ready(out_ready), .elem_out(b_elem_out), .overflow(b_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Present one element and hold it until accepted (bounded).
    task automatic push(input logic [31:0] e, input logic last);
        int cyc;
        elem_in  = e;
        in_last  = last;
        in_valid = 1'b1;
        cyc = 0;
        while (!a_in_ready && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("accept_ready", {31'd0, a_in_ready}, 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called #1 after the edge that accepted the last element.
    task automatic expect_result(input string tag, input logic [31:0] ea, input logic oa,
                                 input logic [31:0] eb, input logic ob);
        int cyc;
        check({tag, "_cvt_valid"}, {31'd0, a_out_valid}, 32'd0);
        check({tag, "_cvt_ready"}, {31'd0, a_in_ready}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_latency_a"}, {31'd0, a_out_valid}, 32'd1);
        check({tag, "_latency_b"}, {31'd0, b_out_valid}, 32'd1);
        cyc = 0;
        while (!a_out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_elem_a"}, a_elem_out, ea);
        check({tag, "_ovf_a"}, {31'd0, a_overflow}, {31'd0, oa});
        check({tag, "_elem_b"}, b_elem_out, eb);
        check({tag, "_ovf_b"}, {31'd0, b_overflow}, {31'd0, ob});
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, {31'd0, a_out_valid}, 32'd0);
        check({tag, "_hs_ready"}, {31'd0, a_in_ready}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;

        // Vector table: bundles with hand-computed float results.
        foreach (vecs[i]) vecs[i].elems = '0;
        vecs[0].n = 4; vecs[0].elems[0] = P; vecs[0].elems[1] = P; vecs[0].elems[2] = P; vecs[0].elems[3] = N;
        vecs[0].exp_a = 32'h4000_0000; vecs[0].ovf_a = 1'b0; vecs[0].exp_b = 32'h4000_0000; vecs[0].ovf_b = 1'b0;
        vecs[1].n = 5; for (int k = 0; k < 5; k++) vecs[1].elems[k] = N;
        vecs[1].exp_a = 32'hC0A0_0000; vecs[1].ovf_a = 1'b0; vecs[1].exp_b = 32'hC0A0_0000; vecs[1].ovf_b = 1'b0;
        vecs[2].n = 2; vecs[2].elems[0] = P; vecs[2].elems[1] = N;
        vecs[2].exp_a = 32'h0000_0000; vecs[2].ovf_a = 1'b0; vecs[2].exp_b = 32'h0000_0000; vecs[2].ovf_b = 1'b0;
        vecs[3].n = 3; vecs[3].elems[0] = Z; vecs[3].elems[1] = NZ; vecs[3].elems[2] = P;
        vecs[3].exp_a = 32'h3F80_0000; vecs[3].ovf_a = 1'b0; vecs[3].exp_b = 32'h3F80_0000; vecs[3].ovf_b = 1'b0;
        // +inf -> +1, negative NaN -> -1, denormal -> 0, 1.5 -> +1 : sum 1
        vecs[4].n = 4; vecs[4].elems[0] = 32'h7F80_0000; vecs[4].elems[1] = 32'hFFC0_0000;
        vecs[4].elems[2] = 32'h0040_0000; vecs[4].elems[3] = 32'h3FC0_0000;
        vecs[4].exp_a = 32'h3F80_0000; vecs[4].ovf_a = 1'b0; vecs[4].exp_b = 32'h3F80_0000; vecs[4].ovf_b = 1'b0;
        vecs[5].n = 1; vecs[5].elems[0] = P;
        vecs[5].exp_a = 32'h3F80_0000; vecs[5].ovf_a = 1'b0; vecs[5].exp_b = 32'h3F80_0000; vecs[5].ovf_b = 1'b0;
        vecs[6].n = 9; for (int k = 0; k < 9; k++) vecs[6].elems[k] = P;
        vecs[6].exp_a = 32'h4110_0000; vecs[6].ovf_a = 1'b0;
`ifdef BUNDLE_SATURATE_EN
        vecs[6].exp_b = 32'h40E0_0000; vecs[6].ovf_b = 1'b1;
`else
        vecs[6].exp_b = 32'hC0E0_0000; vecs[6].ovf_b = 1'b0;
`endif
        vecs[7].n = 1; vecs[7].elems[0] = N;
        vecs[7].exp_a = 32'hBF80_0000; vecs[7].ovf_a = 1'b0; vecs[7].exp_b = 32'hBF80_0000; vecs[7].ovf_b = 1'b0;

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        elem_in   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_elem_out", a_elem_out, 32'd0);
        check("rst_overflow", {31'd0, b_overflow}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven bundles.
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < vecs[i].n; k++) begin
                push(vecs[i].elems[k], (k == vecs[i].n - 1));
            end
            expect_result($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].ovf_a,
                          vecs[i].exp_b, vecs[i].ovf_b);
            handshake($sformatf("vec%0d", i));
        end

        // Backpressure: result held while upstream keeps offering an element.
        push(P, 1'b0);
        push(P, 1'b1);
        expect_result("bp", 32'h4000_0000, 1'b0, 32'h4000_0000, 1'b0);
        held      = a_elem_out;
        elem_in   = P;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, a_out_valid}, 32'd1);
            check("bp_elem_stable", a_elem_out, 32'h4000_0000);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("bp_elem_held", a_elem_out, held);
        handshake("bp");
        push(P, 1'b1);
        expect_result("bp_next", 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0);
        handshake("bp_next");

        // Asynchronous reset mid-bundle discards the partial sum.
        push(P, 1'b0);
        push(P, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_mid_in_ready", {31'd0, a_in_ready}, 32'd1);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        push(P, 1'b1);
        expect_result("after_rst", 32'h3F80_0000, 1'b0, 32'h3F80_0000, 1'b0);

        // Asynchronous reset during HOLD drops the pending result.
        #2 reset_n = 1'b0;
        #1;
        check("rst_hold_out_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_hold_in_ready", {31'd0, a_in_ready}, 32'd1);
        check("rst_hold_elem", a_elem_out, 32'd0);
        #2 reset_n = 1'b1;
        @(posedge clk); #1;
        push(N, 1'b1);
        expect_result("after_rst2", 32'hBF80_0000, 1'b0, 32'hBF80_0000, 1'b0);
        handshake("after_rst2");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
